// File: rtl/gpio_pkg.sv
// Shared constants and types for the memory-mapped GPIO responder.
// GPIO_LED_BLINK_EN adds the BLINK_MASK register at OFF_BLINK_MASK.
package gpio_pkg;

    localparam int DATA_W = 64;

    localparam int OFF_SW_DATA    = 'h00;
    localparam int OFF_LED_OUT    = 'h08;
    localparam int OFF_SW_EDGE    = 'h10;
    localparam int OFF_IRQ_EN     = 'h18;
    localparam int OFF_BLINK_MASK = 'h20;

    typedef logic [7:0] gpio_vec_t;

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-flop synchroniser followed by a saturating stability counter.
// rise pulses in the cycle before the debounced output goes 0->1.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic deb,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic          prev;
    logic [CW-1:0] cnt;
    logic          stable_done;

    // The sync==prev term keeps a saturated counter from accepting the first cycle of a change.
    assign stable_done = (cnt == CNT_MAX) && (sync == prev);
    assign rise        = stable_done && sync && !deb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            cnt  <= '0;
            deb  <= 1'b0;
        end else begin
            meta <= sw_raw;
            sync <= meta;
            prev <= sync;
            if (sync != prev)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            if (stable_done && (sync != deb))
                deb <= sync;
        end
    end

endmodule

// File: rtl/mmio_gpio_responder.sv
// MMIO target owning the board switches and LEDs: register file, decode and req/ack handshake.
// Optional GPIO_LED_BLINK_EN adds BLINK_MASK and a free-running blink prescaler.
module mmio_gpio_responder
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ADDR_W          = 8,
    parameter int BLINK_DIV_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    input  logic [7:0]        SW,
    output logic [7:0]        LED,
    output logic              irq
);
    // Handshake: req is a one-cycle request sampled at an edge; ack (with err on an
    // unmapped offset) is high for exactly the next cycle with rdata valid, otherwise
    // rdata is 0. There is no back-pressure, so req may be issued every cycle.
    gpio_vec_t         sw_deb;
    gpio_vec_t         sw_rise;
    gpio_vec_t         led_out;
    gpio_vec_t         irq_en;
    gpio_vec_t         sw_edge;
    gpio_vec_t         w1c_mask;
    logic [ADDR_W-1:0] off;
    logic              wr;
    logic              hit;
    logic [DATA_W-1:0] rd_val;
    logic              unused_bits;
`ifdef GPIO_LED_BLINK_EN
    gpio_vec_t             blink_mask;
    logic [BLINK_DIV_W-1:0] presc;
    logic                   phase;
`endif

    assign off         = {addr[ADDR_W-1:3], 3'b000};
    assign wr          = req && we;
    assign unused_bits = ^{wdata[DATA_W-1:8], addr[2:0]};

    for (genvar i = 0; i < 8; i++) begin : g_sw
        sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .sw_raw (SW[i]),
            .deb    (sw_deb[i]),
            .rise   (sw_rise[i])
        );
    end

    always_comb begin
        hit      = 1'b1;
        rd_val   = '0;
        w1c_mask = '0;
        case (off)
            ADDR_W'(OFF_SW_DATA):    rd_val = DATA_W'(sw_deb);
            ADDR_W'(OFF_LED_OUT):    rd_val = DATA_W'(led_out);
            ADDR_W'(OFF_SW_EDGE):    rd_val = DATA_W'(sw_edge);
            ADDR_W'(OFF_IRQ_EN):     rd_val = DATA_W'(irq_en);
`ifdef GPIO_LED_BLINK_EN
            ADDR_W'(OFF_BLINK_MASK): rd_val = DATA_W'(blink_mask);
`endif
            default:                 hit    = 1'b0;
        endcase
        if (wr && (off == ADDR_W'(OFF_SW_EDGE)))
            w1c_mask = wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata   <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;
            led_out <= '0;
            irq_en  <= '0;
            sw_edge <= '0;
            irq     <= 1'b0;
        end else begin
            ack   <= req;
            err   <= req && !hit;
            rdata <= req ? rd_val : '0;
            if (wr && (off == ADDR_W'(OFF_LED_OUT)))
                led_out <= wdata[7:0];
            if (wr && (off == ADDR_W'(OFF_IRQ_EN)))
                irq_en <= wdata[7:0];
            // A rising edge in the same cycle as its W1C keeps the flag set.
            sw_edge <= (sw_edge & ~w1c_mask) | sw_rise;
            irq     <= |(sw_edge & irq_en);
        end
    end

`ifdef GPIO_LED_BLINK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_mask <= '0;
            presc      <= '0;
            phase      <= 1'b0;
        end else begin
            presc <= presc + BLINK_DIV_W'(1);
            if (&presc)
                phase <= ~phase;
            if (wr && (off == ADDR_W'(OFF_BLINK_MASK)))
                blink_mask <= wdata[7:0];
        end
    end

    assign LED = led_out & ~(blink_mask & {8{phase}});
`else
    localparam int unused_blink_div_w = BLINK_DIV_W;
    assign LED = led_out;
`endif

endmodule

// File: doc/mmio_gpio_responder.md
Name: mmio_gpio_responder

Overview:
- Memory-mapped GPIO responder for the 64-bit single-cycle core; the core's load/store path is the initiator, this block the target.
- Owns the board switches (SW) and LEDs.
- Synchronises and debounces SW, latches LED writes from STUR, returns register contents to LDUR with a one-cycle handshake.
- Sits between the data-memory address decode and the board pins.

Parameters:
- DEBOUNCE_CYCLES, 16, clk cycles a synchronised SW value must stay stable before it is accepted (min 2).
- ADDR_W, 8, width of the word-aligned offset bus.
- BLINK_DIV_W, 24, blink prescaler width (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  1  access request, one-cycle pulse from the core
- we  input  1  1 = write, 0 = read; sampled with req
- addr  input  ADDR_W  byte offset; bits [2:0] ignored
- wdata  input  64  write data
- rdata  output  64  read data, valid while ack = 1
- ack  output  1  one-cycle response pulse
- err  output  1  one-cycle pulse with ack on an unmapped offset
- SW  input  8  raw board switches, asynchronous
- LED  output  8  board LEDs
- irq  output  1  level, high while any enabled edge flag is set

Behaviour:
- Reset: async on rst_n low. rdata=0, ack=0, err=0, LED=0, irq=0; every internal register cleared, debounced SW value=0.
- Register map (offsets):
  - 0x00 SW_DATA, RO: {56'b0, debounced SW}.
  - 0x08 LED_OUT, RW: bits [7:0] drive LED; upper bits read 0.
  - 0x10 SW_EDGE, W1C: sticky rising-edge flags of debounced SW. Writing 1 clears a bit.
  - 0x18 IRQ_EN, RW, bits [7:0].
  - Any other offset: write ignored, read returns 0, err=1.
- Handshake:
  - req sampled at edge N; ack (and err if applicable) high for exactly cycle N+1; rdata valid in the same cycle; rdata=0 whenever ack=0.
  - Write takes effect at edge N (LED updates at N+1).
  - req asserted while ack is high is accepted normally, giving back-to-back 1-per-cycle throughput.
- Input synchroniser: 2-flop synchroniser on SW.
- Debounce, per bit:
  - The counter resets whenever the synchronised bit differs from its previous-cycle value.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the synchronised bit differs from the debounced bit, the debounced bit updates on the next edge.
  - The counter saturates and does not wrap.
- Total SW-to-SW_DATA latency: 2 + DEBOUNCE_CYCLES cycles for a clean step.
- Edge flags:
  - Set when a debounced bit goes 0→1.
  - Simultaneous set and W1C on the same bit: set wins.
- irq = |(SW_EDGE & IRQ_EN[7:0]), registered, updates one cycle after a flag or enable changes.
- Reset mid-access: pending ack is dropped and no write effect persists.

Optional Feature:
- Macro: GPIO_LED_BLINK_EN.
- When defined:
  - Adds register 0x20 BLINK_MASK (RW, bits [7:0]).
  - A free-running BLINK_DIV_W-bit prescaler toggles a blink phase on wrap.
  - LED = LED_OUT & ~(BLINK_MASK & {8{phase}}).
  - Prescaler and phase reset to 0.
- When not defined: 0x20 is unmapped (err=1), LED = LED_OUT, and no prescaler logic exists.

Decomposition:
- Package gpio_pkg:
  - Offset constants OFF_SW_DATA, OFF_LED_OUT, OFF_SW_EDGE, OFF_IRQ_EN, OFF_BLINK_MASK.
  - Data width constant 64.
  - Typedef for the 8-bit gpio vector.
- Sub-module sw_debounce:
  - One instance per bit via generate.
  - Contains the synchroniser, counter and debounced output, parameterised by DEBOUNCE_CYCLES.
- The top holds the register file, decode and handshake.

Test Plan:
- Reset: hold rst_n=0 with SW=8'hFF, release → LED=0, irq=0; read 0x00 within 2 cycles returns 0.
- Debounce: SW 0→8'h05 clean step → read 0x00 returns 0 before cycle 2+16 and 8'h05 from cycle 18 onward; glitch of 5 cycles on SW[7] → never seen.
- LED write/read: write 0x08 with 64'hFFFF_FFFF_FFFF_FF3C → LED=8'h3C next cycle; read back returns 64'h3C; ack one pulse each; err=0.
- Edge/irq: IRQ_EN=8'h01, SW[0] rises → SW_EDGE=8'h01 and irq=1; write 0x10 with 1 → flag clears and irq=0 next cycle; set and clear in the same cycle → flag stays 1.
- Unmapped: read 0x28 → ack=1, err=1, rdata=0; write 0x30 → no register changes.
- Back-to-back: req on 4 consecutive cycles (W 0x08=0xA5, R 0x08, R 0x00, W 0x18=0x0F) → 4 ack pulses; second returns 0xA5.
